// File: rtl/midi_note_parser.sv
// MIDI note-on/note-off parser for a single channel, with running status.
// It drives the held note number, velocity and gate to the note2dds stage.
module midi_note_parser #(
    parameter int unsigned CHANNEL      = 0,
    parameter logic [7:0]  DEFAULT_NOTE = 8'd69
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_note,
    output logic [6:0] o_velocity,
    output logic       o_gate,
    output logic       o_note_stb,
    output logic       o_err
);

    localparam logic [3:0] LP_CHANNEL    = CHANNEL[3:0];
    localparam logic [7:0] LP_RESET_NOTE = {1'b0, DEFAULT_NOTE[6:0]};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        WAIT_VEL
    } state_t;

    state_t     r_state, w_state_next;
    logic       r_is_on, w_is_on_next;
    logic [6:0] r_key, w_key_next;
    logic [7:0] r_note, w_note_next;
    logic [6:0] r_vel, w_vel_next;
    logic       r_gate, w_gate_next;
    logic       r_stb, w_stb_next;
    logic       r_err, w_err_next;

    logic w_is_status;
    logic w_is_realtime;
    logic w_is_ours;

    assign w_is_status   = i_rx_byte[7];
    assign w_is_realtime = (i_rx_byte[7:3] == 5'b11111);
    // 0x8n and 0x9n share the top three bits; bit 4 selects note-on.
    assign w_is_ours     = (i_rx_byte[7:5] == 3'b100) && (i_rx_byte[3:0] == LP_CHANNEL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_is_on <= 1'b0;
            r_key   <= 7'd0;
        end else begin
            r_state <= w_state_next;
            r_is_on <= w_is_on_next;
            r_key   <= w_key_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_note <= LP_RESET_NOTE;
            r_vel  <= 7'd0;
            r_gate <= 1'b0;
            r_stb  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_note <= w_note_next;
            r_vel  <= w_vel_next;
            r_gate <= w_gate_next;
            r_stb  <= w_stb_next;
            r_err  <= w_err_next;
        end
    end

    // Real-time bytes are transparent; everything else is decoded here.
    always_comb begin
        w_state_next = r_state;
        w_is_on_next = r_is_on;
        w_key_next   = r_key;
        w_note_next  = r_note;
        w_vel_next   = r_vel;
        w_gate_next  = r_gate;
        w_stb_next   = 1'b0;
        w_err_next   = 1'b0;
        if (i_rx_valid && !w_is_realtime) begin
            if (w_is_status) begin
                w_err_next = (r_state == WAIT_VEL);
                if (w_is_ours) begin
                    w_state_next = WAIT_KEY;
                    w_is_on_next = i_rx_byte[4];
                end else begin
                    w_state_next = IDLE;
                    w_is_on_next = 1'b0;
                end
            end else begin
                case (r_state)
                    WAIT_KEY: begin
                        w_key_next   = i_rx_byte[6:0];
                        w_state_next = WAIT_VEL;
                    end
                    WAIT_VEL: begin
                        w_state_next = WAIT_KEY;
                        if (r_is_on && (i_rx_byte[6:0] != 7'd0)) begin
                            w_note_next = {1'b0, r_key};
                            w_vel_next  = i_rx_byte[6:0];
                            w_gate_next = 1'b1;
                            w_stb_next  = 1'b1;
                        end else if (r_gate && (r_note == {1'b0, r_key})) begin
                            w_gate_next = 1'b0;
                            w_stb_next  = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_note     = r_note;
    assign o_velocity = r_vel;
    assign o_gate     = r_gate;
    assign o_note_stb = r_stb;
    assign o_err      = r_err;

endmodule

// File: doc/midi_note_parser.md
MIDI_NOTE_PARSER -- requirements
Module: midi_note_parser

Interface
REQ-001 Parameter CHANNEL, default 0, MIDI channel (0-15) accepted; other channels ignored.
REQ-002 Parameter DEFAULT_NOTE, default 69, NOTE value after reset (A4, 440 Hz).
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset; while 0 all state holds reset values.
REQ-005 RX_BYTE  input  8  received MIDI byte from the UART stage.
REQ-006 RX_VALID  input  1  RX_BYTE qualifier, one-cycle pulse per byte; ignored when 0.
REQ-007 NOTE  output  8  current note number, bit 7 always 0; drives note2dds NOTE input.
REQ-008 VELOCITY  output  7  velocity of the note-on that set NOTE.
REQ-009 GATE  output  1  1 while the current note is held.
REQ-010 NOTE_STB  output  1  one-cycle pulse when NOTE/VELOCITY/GATE change due to a message.
REQ-011 ERR  output  1  one-cycle pulse on a protocol violation (REQ-024).

Function
REQ-012 Byte class: bit 7 = 1 is status, bit 7 = 0 is data; only cycles with RX_VALID = 1 are evaluated.
REQ-013 FSM states: IDLE (no running status), WAIT_KEY, WAIT_VEL.
REQ-014 Status 0x9n or 0x8n with n = CHANNEL: latch message type (ON/OFF) as running status, go to WAIT_KEY.
REQ-015 Status 0x8n/0x9n with n != CHANNEL, or any other 0x80-0xEF status: clear running status, go to IDLE; following data bytes are discarded.
REQ-016 System common 0xF0-0xF7: clear running status, go to IDLE.
REQ-017 Real-time 0xF8-0xFF: no effect on state, running status or outputs, in any state.
REQ-018 WAIT_KEY + data byte: latch key, go to WAIT_VEL.
REQ-019 WAIT_VEL + data byte: execute message on that cycle, return to WAIT_KEY (running status retained).
REQ-020 IDLE + data byte: discard, stay IDLE, no output change.
REQ-021 Execute ON with velocity > 0: next cycle NOTE = key, VELOCITY = vel, GATE = 1, NOTE_STB = 1 (last-note priority; retrigger of same key also pulses NOTE_STB).
REQ-022 Execute OFF, or ON with velocity 0: if key == NOTE and GATE = 1, next cycle GATE = 0, NOTE_STB = 1, NOTE and VELOCITY held; otherwise no output change, no strobe.
REQ-023 Latency: outputs update on the rising edge following the cycle that carries the velocity byte (1 cycle); NOTE_STB high exactly one cycle.
REQ-024 Status byte (other than real-time) arriving in WAIT_VEL: ERR pulses 1 cycle next cycle, partial message dropped, new status processed per REQ-014..016 in the same cycle.
REQ-025 Back-to-back RX_VALID on consecutive cycles supported; no byte lost.
REQ-026 NOTE holds last value indefinitely with GATE = 0 so the downstream DDS keeps a defined frequency.

Reset
REQ-027 RESET = 0: asynchronously NOTE = DEFAULT_NOTE, VELOCITY = 0, GATE = 0, NOTE_STB = 0, ERR = 0, FSM = IDLE, running status cleared.
REQ-028 Reset mid-message: partial message discarded; after release, data bytes are discarded until a valid status byte arrives.
REQ-029 First byte evaluated is the one with RX_VALID = 1 on the first rising edge after RESET returns to 1.

Verification
REQ-030 Reset: RESET low 100 ns -> NOTE = 69, VELOCITY = 0, GATE = 0, NOTE_STB = 0, ERR = 0.
REQ-031 Note-on: bytes 0x90,0x3C,0x64 (CHANNEL = 0) -> one cycle after 0x64: NOTE = 60, VELOCITY = 100, GATE = 1, one NOTE_STB pulse.
REQ-032 Running status + vel-0 off: after REQ-031, bytes 0x40,0x50 then 0x40,0x00 -> NOTE = 64, GATE = 1; then GATE = 0, NOTE = 64, two NOTE_STB pulses total.
REQ-033 Non-matching off: NOTE = 64, GATE = 1; bytes 0x80,0x3C,0x40 -> no output change, no NOTE_STB.
REQ-034 Real-time interleave: 0x90,0xF8,0x45,0xFE,0x7F -> NOTE = 69, VELOCITY = 127, GATE = 1; 0xF8/0xFE produce no effect.
REQ-035 Error/channel: 0x90,0x3C,0xB0 -> ERR pulse, no NOTE_STB; then 0x91,0x3C,0x40 -> ignored (channel 1), outputs unchanged.
